// File: rtl/mips_v3_pkg.sv
// Shared decode constants and enumerations for the v3 multi-cycle core.
package mips_v3_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_ORI   = 6'd2;

    localparam logic [5:0] FN_ADD = 6'h00;
    localparam logic [5:0] FN_SUB = 6'h02;
    localparam logic [5:0] FN_AND = 6'h04;
    localparam logic [5:0] FN_OR  = 6'h05;
    localparam logic [5:0] FN_XOR = 6'h06;
    localparam logic [5:0] FN_SLT = 6'h07;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_NOP
    } alu_op_t;

endpackage

// File: rtl/mips_regfile_v3.sv
// Register file: two combinational read ports, a debug read port and one
// synchronous write port; register 0 is hardwired to zero.
module mips_regfile_v3 #(
    parameter int DATA_W = 32,
    parameter int REG_NUM = 32,
    localparam int REG_AW = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [REG_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1      = (ra1 == '0)      ? '0 : regs[ra1];
    assign rd2      = (ra2 == '0)      ? '0 : regs[ra2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/mips_core_v3.sv
// Multi-cycle execution core: valid/ready instruction intake, then
// READ -> EXEC -> WB over the register file, one instruction per 4 cycles.
module mips_core_v3
    import mips_v3_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_NUM = 32,
    parameter int CNT_W = 16,
    localparam int REG_AW = $clog2(REG_NUM)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       INST,
    input  logic              write,
    output logic [DATA_W-1:0] ALUA,
    output logic [DATA_W-1:0] ALUB,
    output logic [DATA_W-1:0] out,
    output logic              flag,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired_cnt,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    state_t            next_state;
    logic [31:0]       inst_q;
    alu_op_t           alu_op;
    logic              rtype;
    logic              wen_dec;
    logic              bad_op;
    logic [4:0]        dest;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rf_we;

    mips_regfile_v3 #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM)
    ) u_regfile (
        .clk      (CLK),
        .rst      (RST),
        .ra1      (REG_AW'(inst_q[25:21])),
        .ra2      (REG_AW'(inst_q[20:16])),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wa       (REG_AW'(dest)),
        .wd       (out)
    );

    always_comb begin
        alu_op  = ALU_NOP;
        rtype   = 1'b0;
        wen_dec = 1'b0;
        bad_op  = 1'b0;
        dest    = inst_q[15:11];
        imm_ext = DATA_W'(signed'(inst_q[15:0]));
        case (inst_q[31:26])
            OP_RTYPE: begin
                rtype   = 1'b1;
                wen_dec = 1'b1;
                case (inst_q[5:0])
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: wen_dec = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_op  = ALU_ADD;
                wen_dec = 1'b1;
                dest    = inst_q[20:16];
            end
            OP_ORI: begin
                alu_op  = ALU_OR;
                wen_dec = 1'b1;
                dest    = inst_q[20:16];
                imm_ext = DATA_W'(inst_q[15:0]);
            end
            default: bad_op = 1'b1;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = ALUA + ALUB;
            ALU_SUB: alu_res = ALUA - ALUB;
            ALU_AND: alu_res = ALUA & ALUB;
            ALU_OR:  alu_res = ALUA | ALUB;
            ALU_XOR: alu_res = ALUA ^ ALUB;
            ALU_SLT: alu_res = ($signed(ALUA) < $signed(ALUB)) ? DATA_W'(1) : '0;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A reset landing in WB must neither pulse done nor commit the write.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        rf_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = ST_READ;
                end
            end
            ST_READ: next_state = ST_EXEC;
            ST_EXEC: next_state = ST_WB;
            ST_WB: begin
                done       = ~RST;
                rf_we      = write & wen_dec & ~RST;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            inst_q      <= '0;
            ALUA        <= '0;
            ALUB        <= '0;
            out         <= '0;
            flag        <= 1'b1;
            illegal     <= 1'b0;
            retired_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        inst_q <= INST;
                    end
                end
                ST_READ: begin
                    ALUA <= rd1;
                    ALUB <= rtype ? rd2 : imm_ext;
                end
                ST_EXEC: begin
                    out  <= alu_res;
                    flag <= (alu_res == '0);
                    if (bad_op) begin
                        illegal <= 1'b1;
                    end
                end
                ST_WB: retired_cnt <= retired_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_core_v3.sv
// Self-checking bench for mips_core_v3: directed vector table, handshake,
// illegal and reset corner cases, then random programs against a reference model.
module tb_mips_core_v3;

    logic        clk = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        write;
    logic [31:0] INST;
    logic [4:0]  dbg_addr;
    logic        in_ready, flag, done, illegal;
    logic [31:0] ALUA, ALUB, out, dbg_data;
    logic [15:0] retired_cnt;

    logic        in_ready16, flag16, done16, illegal16;
    logic [15:0] alua16, alub16, out16, dbg_data16, cnt16;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [31:0] mregs [32];
    logic [15:0] m_cnt;
    logic        m_ill;

    typedef struct {
        logic [31:0] inst;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] val;
        logic        chk_out;
        logic [31:0] exp_out;
    } vec_t;

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    mips_core_v3 dut (
        .CLK(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .INST(INST), .write(write), .ALUA(ALUA), .ALUB(ALUB), .out(out),
        .flag(flag), .done(done), .illegal(illegal), .retired_cnt(retired_cnt),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    mips_core_v3 #(.DATA_W(16)) dut16 (
        .CLK(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready16),
        .INST(INST), .write(write), .ALUA(alua16), .ALUB(alub16), .out(out16),
        .flag(flag16), .done(done16), .illegal(illegal16), .retired_cnt(cnt16),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data16)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        m_cnt = '0;
        m_ill = 1'b0;
    endtask

    // Architectural effect of one instruction, straight from the ISA rules.
    task automatic modelStep(input logic [31:0] inst, input logic wr,
                             output logic [31:0] res, output logic [31:0] a,
                             output logic [31:0] b, output int dst,
                             output logic has_res, output logic chk_b);
        logic [15:0] imm;
        imm     = inst[15:0];
        a       = mregs[inst[25:21]];
        b       = '0;
        res     = '0;
        has_res = 1'b1;
        chk_b   = 1'b1;
        dst     = inst[20:16];
        case (inst[31:26])
            6'd0: begin
                b   = mregs[inst[20:16]];
                dst = inst[15:11];
                case (inst[5:0])
                    6'h00: res = a + b;
                    6'h02: res = a - b;
                    6'h04: res = a & b;
                    6'h05: res = a | b;
                    6'h06: res = a ^ b;
                    6'h07: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: has_res = 1'b0;
                endcase
            end
            6'd1: begin b = {{16{imm[15]}}, imm}; res = a + b; end
            6'd2: begin b = {16'h0, imm};          res = a | b; end
            default: begin has_res = 1'b0; chk_b = 1'b0; m_ill = 1'b1; end
        endcase
        if (has_res && wr && dst != 0) mregs[dst] = res;
        m_cnt = m_cnt + 16'd1;
    endtask

    task automatic applyStimulus(input logic [31:0] inst, input logic wr);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL ready_timeout: got in_ready=%0b expected 1", in_ready);
        end
        INST = inst;
        write = wr;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finishInstr(input logic [31:0] inst, input logic wr);
        bit seen = 0;
        logic [31:0] res, a, b;
        int dst;
        logic has_res, chk_b;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL done_timeout: got done=%0b expected 1", done);
            return;
        end
        modelStep(inst, wr, res, a, b, dst, has_res, chk_b);
        @(negedge clk);
        checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
        checkOutput("in_ready_after_wb", {31'b0, in_ready}, 32'd1);
        checkOutput("retired_cnt", {16'b0, retired_cnt}, {16'b0, m_cnt});
        checkOutput("illegal", {31'b0, illegal}, {31'b0, m_ill});
        checkOutput("alua", ALUA, a);
        if (chk_b) checkOutput("alub", ALUB, b);
        if (has_res) begin
            checkOutput("out", out, res);
            checkOutput("flag", {31'b0, flag}, {31'b0, (res == 0)});
        end
        dbg_addr = dst[4:0];
        #1 checkOutput("dest_reg", dbg_data, mregs[dst]);
        dbg_addr = 5'($urandom_range(0, 31));
        #1 checkOutput("any_reg", dbg_data, mregs[dbg_addr]);
    endtask

    task automatic issue(input logic [31:0] inst, input logic wr);
        applyStimulus(inst, wr);
        finishInstr(inst, wr);
    endtask

    task automatic applyReset();
        RST = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        modelReset();
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs [9];
        logic [5:0] fns [7];
        int base;
        logic [31:0] inst;
        logic wr;

        vecs[0] = '{32'h04080001, 1'b1, 5'd8, 32'd1,          1'b1, 32'd1};
        vecs[1] = '{32'h00084800, 1'b1, 5'd9, 32'd1,          1'b1, 32'd1};
        vecs[2] = '{32'h05080001, 1'b1, 5'd8, 32'd2,          1'b1, 32'd2};
        vecs[3] = '{32'h01094800, 1'b1, 5'd9, 32'd3,          1'b1, 32'd3};
        vecs[4] = '{32'h0000000A, 1'b1, 5'd9, 32'd3,          1'b0, 32'd0};
        vecs[5] = '{32'h0401FFFF, 1'b1, 5'd1, 32'hFFFFFFFF,   1'b1, 32'hFFFFFFFF};
        vecs[6] = '{32'h00011002, 1'b1, 5'd2, 32'd1,          1'b1, 32'd1};
        vecs[7] = '{32'h04030005, 1'b0, 5'd3, 32'd0,          1'b1, 32'd5};
        vecs[8] = '{32'h04000007, 1'b1, 5'd0, 32'd0,          1'b1, 32'd7};
        fns = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h0A};

        INST = '0;
        write = 1'b1;
        dbg_addr = '0;
        applyReset();

        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_flag", {31'b0, flag}, 32'd1);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_illegal", {31'b0, illegal}, 32'd0);
        checkOutput("rst_cnt", {16'b0, retired_cnt}, 32'd0);
        checkOutput("rst_out", out, 32'd0);
        checkOutput("rst_alua", ALUA, 32'd0);
        checkOutput("rst_alub", ALUB, 32'd0);

        base = done_cnt;
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].inst, vecs[i].wr);
            dbg_addr = vecs[i].addr;
            #1 checkOutput("vec_reg", dbg_data, vecs[i].val);
            if (vecs[i].chk_out) checkOutput("vec_out", out, vecs[i].exp_out);
            if (i == 3) begin
                checkOutput("vec_done_pulses", done_cnt - base, 32'd4);
                checkOutput("vec_cnt4", {16'b0, retired_cnt}, 32'd4);
            end
            if (i == 6) begin
                dbg_addr = 5'd1;
                #1 checkOutput("w16_r1", {16'b0, dbg_data16}, 32'h0000FFFF);
                dbg_addr = 5'd2;
                #1 checkOutput("w16_r2", {16'b0, dbg_data16}, 32'd1);
            end
        end
        checkOutput("write0_flag", {31'b0, flag}, 32'd0);

        // Second instruction offered during READ/EXEC/WB must wait for IDLE.
        applyStimulus(32'h04050011, 1'b1);
        INST = 32'h04060022;
        in_valid = 1'b1;
        checkOutput("hs_read_busy", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("hs_exec_busy", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("hs_wb_busy", {31'b0, in_ready}, 32'd0);
        finishInstr(32'h04050011, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        finishInstr(32'h04060022, 1'b1);

        issue(32'hFC000000, 1'b1);
        checkOutput("illegal_set", {31'b0, illegal}, 32'd1);
        issue(32'h080700F0, 1'b1);
        checkOutput("illegal_sticky", {31'b0, illegal}, 32'd1);

        // Reset while ADDI r4,r0,9 sits in EXEC.
        applyStimulus(32'h04040009, 1'b1);
        @(negedge clk);
        base = done_cnt;
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_mid_illegal", {31'b0, illegal}, 32'd0);
        checkOutput("rst_mid_cnt", {16'b0, retired_cnt}, 32'd0);
        checkOutput("rst_mid_flag", {31'b0, flag}, 32'd1);
        dbg_addr = 5'd4;
        #1 checkOutput("rst_mid_r4", dbg_data, 32'd0);
        dbg_addr = 5'd8;
        #1 checkOutput("rst_mid_r8", dbg_data, 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("rst_mid_no_done", done_cnt - base, 32'd0);

        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k <= 4)
                inst = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                        fns[$urandom_range(0, 6)]};
            else if (k <= 6)
                inst = {6'd1, 5'($urandom), 5'($urandom), 16'($urandom)};
            else if (k <= 8)
                inst = {6'd2, 5'($urandom), 5'($urandom), 16'($urandom)};
            else
                inst = {6'($urandom_range(3, 63)), 26'($urandom)};
            wr = ($urandom_range(0, 9) != 0);
            issue(inst, wr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_core_v3.md
Name: mips_core_v3

Overview:
Parametrised multi-cycle execution core that replaces the fixed-width v2 top. Instructions arrive on a valid/ready handshake instead of being held on INST for a fixed number of cycles. Each accepted instruction is read, executed and written back by an internal FSM into a register file of configurable width and depth. ALU operands, result, zero flag, illegal flag and retired count are exposed for bench monitoring.

Parameters:
DATA_W, 32, datapath and register width; legal range 16 to 64.
REG_NUM, 32, number of architectural registers; power of 2, at most 32.
REG_AW, $clog2(REG_NUM), register address width; derived, not overridden.
CNT_W, 16, width of the retired-instruction counter.

Ports:
CLK  input  1  clock; all state updates on posedge.
RST  input  1  synchronous active-high reset.
in_valid  input  1  INST is valid this cycle.
in_ready  output  1  core can accept an instruction (state IDLE).
INST  input  32  instruction word; opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].
write  input  1  global writeback enable; when 0, results are computed but not stored.
ALUA  output  DATA_W  registered ALU operand A.
ALUB  output  DATA_W  registered ALU operand B (rt value or extended immediate).
out  output  DATA_W  registered ALU result.
flag  output  1  zero flag; 1 when out == 0.
done  output  1  one-cycle pulse in the WB cycle.
illegal  output  1  sticky; set by an unknown opcode.
retired_cnt  output  CNT_W  count of completed instructions, including NOPs.
dbg_addr  input  REG_AW  debug read address.
dbg_data  output  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values:
  - FSM goes to IDLE.
  - All registers are 0.
  - ALUA, ALUB and out are 0.
  - flag=1, done=0, illegal=0, retired_cnt=0.
  - in_ready=1 from the first cycle after RST deasserts.
- FSM states are IDLE, READ, EXEC, WB.
  - IDLE: in_ready=1. When in_valid=1, latch INST into the instruction register and go to READ.
  - READ: load ALUA with reg[rs]. Load ALUB with reg[rt] for R-type, or with the extended immediate for I-type. Go to EXEC.
  - EXEC: out <= ALU(ALUA, ALUB); flag <= (ALU result == 0). Go to WB.
  - WB:
    - If the write enable is set and the destination is nonzero, write out to the destination register.
    - done=1; retired_cnt is incremented, wrapping at 2^CNT_W.
    - Go to IDLE.
- Latency: handshake accept at cycle N gives writeback visible on dbg_data at N+4. Maximum throughput is one instruction per 4 cycles.
- Handshake: in_ready is low in READ, EXEC and WB. in_valid during those states is ignored and not queued; the producer holds INST until it sees in_ready.
- Decode, opcode 0 (R-type), destination rd:
  - funct 0x00: ADD.
  - funct 0x02: SUB.
  - funct 0x04: AND.
  - funct 0x05: OR.
  - funct 0x06: XOR.
  - funct 0x07: SLT (signed; result is 1 or 0).
  - Any other funct (e.g. 0x0A) is a NOP: passes through all states, no write, counts as retired.
- Decode, I-type, destination rt:
  - opcode 1: ADDI, sign-extended imm.
  - opcode 2: ORI, zero-extended imm.
- Any other opcode: sets illegal, performs no write, still retires.
- Arithmetic: modulo 2^DATA_W. No overflow trap. The immediate is extended to DATA_W.
- Register 0 reads as 0 always; writes to it are dropped.
- Read/write ordering: WB completes before the next READ, so no forwarding is required.
- Reset mid-operation: RST in any state aborts the instruction with no write and no done, returns to IDLE and clears all state.
- Simultaneous events: RST has priority over in_valid.
- dbg_data is purely combinational from the register array. In the cycle after WB it shows the new value.

Decomposition:
- Package mips_v3_pkg holds:
  - opcode constants: OP_RTYPE=6'd0, OP_ADDI=6'd1, OP_ORI=6'd2.
  - funct constants.
  - FSM state enum.
  - ALU-op enum.
- Sub-module mips_regfile_v3 (parameters DATA_W, REG_NUM) provides:
  - two combinational read ports plus the debug read port;
  - one synchronous write port;
  - register 0 hardwired to zero;
  - synchronous clear on RST.
- Decode and ALU stay in mips_core_v3.

Test Plan:
- Reset, then program ADDI r8,r0,1 (0x04080001); ADD r9,r0,r8 (0x00084800); ADDI r8,r8,1 (0x05080001); ADD r9,r8,r9 (0x01094800) -> r8=2, r9=3, retired_cnt=4, done pulses exactly 4 times.
- INST=0x0000000A (funct NOP) -> no register changes, retired_cnt increments by 1, illegal=0.
- ADDI r1,r0,0xFFFF then SUB r2,r0,r1 with DATA_W=32 -> r1=0xFFFFFFFF, r2=1; repeat with DATA_W=16 -> r1=0xFFFF, r2=1.
- write=0 during ADDI r3,r0,5 -> r3 stays 0, out=5, flag=0; ADDI r0,r0,7 -> r0 reads 0.
- in_valid held high with new INST during READ/EXEC -> ignored; next acceptance only 4 cycles after the previous one; opcode 0x3F -> illegal=1 and sticky until RST.
- RST asserted in EXEC of ADDI r4,r0,9 -> r4=0, no done, in_ready=1 the cycle after RST drops, illegal cleared.
